// File: rtl/ca_sweep_sequencer.sv
// Four-phase ADDR/SHIFT/RULE/WRITE sweep sequencer for the cellular-automaton engine.
// Walks every cell address once per generation, with run, single-step and priming control.
module ca_sweep_sequencer #(
  parameter int WIDTH    = 160,
  parameter int HEIGHT   = 120,
  parameter int LEAD     = 161,
  parameter int FAST_DIV = 4,
  parameter int SLOW_DIV = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic        fast,
  output logic [19:0] read_addr,
  output logic [19:0] write_addr,
  output logic        shift_en,
  output logic        rule_en,
  output logic        write_en,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] generation
);

  localparam int N = WIDTH * HEIGHT;
  localparam logic [19:0] LAST      = 20'(N - 1);
  localparam logic [19:0] READ_INIT = 20'(LEAD % N);
  localparam logic [19:0] PRIME_LIM = 20'(LEAD);
  localparam logic [15:0] FAST_LIM  = 16'(FAST_DIV - 1);
  localparam logic [15:0] SLOW_LIM  = 16'(SLOW_DIV - 1);

  typedef enum logic [2:0] {IDLE, ADDR, SHIFT, RULE, WRITE} state_t;

  state_t      state;
  logic [15:0] count;
  logic [19:0] prime;
  logic        single;
  logic [15:0] limit;
  logic        tick;

  function automatic logic [19:0] next_addr(input logic [19:0] a);
    return (a == LAST) ? 20'd0 : a + 20'd1;
  endfunction

  // >= compare keeps a phase bounded when fast drops to a shorter divider mid-phase
  always_comb begin
    limit = fast ? FAST_LIM : SLOW_LIM;
    tick  = (count >= limit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= 16'd0;
      read_addr  <= READ_INIT;
      write_addr <= 20'd0;
      shift_en   <= 1'b0;
      rule_en    <= 1'b0;
      write_en   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      generation <= 16'd0;
      prime      <= 20'd0;
      single     <= 1'b0;
    end else begin
      shift_en   <= 1'b0;
      rule_en    <= 1'b0;
      write_en   <= 1'b0;
      frame_done <= 1'b0;
      if (state == IDLE || tick) begin
        count <= 16'd0;
      end else begin
        count <= count + 16'd1;
      end
      case (state)
        IDLE: begin
          if (run || step) begin
            state  <= ADDR;
            busy   <= 1'b1;
            single <= step;
          end
        end
        ADDR: begin
          if (tick) begin
            state    <= SHIFT;
            shift_en <= 1'b1;
          end
        end
        SHIFT: begin
          if (tick) begin
            state   <= RULE;
            rule_en <= 1'b1;
          end
        end
        RULE: begin
          // the first LEAD cells after reset only fill the neighbourhood pipeline
          if (tick) begin
            state    <= WRITE;
            write_en <= (prime >= PRIME_LIM);
          end
        end
        WRITE: begin
          if (tick) begin
            read_addr  <= next_addr(read_addr);
            write_addr <= next_addr(write_addr);
            if (prime < PRIME_LIM) begin
              prime <= prime + 20'd1;
            end
            if (write_addr == LAST) begin
              frame_done <= 1'b1;
              generation <= generation + 16'd1;
              if (run && !single) begin
                state <= ADDR;
              end else begin
                state  <= IDLE;
                busy   <= 1'b0;
                single <= 1'b0;
              end
            end else begin
              state <= ADDR;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ca_sweep_sequencer.sv
// Self-checking bench for ca_sweep_sequencer: cycle-level behavioural model plus directed
// expectations for priming, stepping, run timing, fast toggling and mid-frame reset.
module tb_ca_sweep_sequencer;
  localparam int W = 4, H = 3, LEAD = 5, FD = 2, SD = 3, N = W * H;

  logic        clk = 1'b0, reset = 1'b1, run = 1'b0, step = 1'b0, fast = 1'b1;
  logic [19:0] read_addr, write_addr;
  logic        shift_en, rule_en, write_en, busy, frame_done;
  logic [15:0] generation;

  always #5 clk = ~clk;

  ca_sweep_sequencer #(.WIDTH(W), .HEIGHT(H), .LEAD(LEAD), .FAST_DIV(FD), .SLOW_DIV(SD)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .fast(fast),
    .read_addr(read_addr), .write_addr(write_addr), .shift_en(shift_en), .rule_en(rule_en),
    .write_en(write_en), .busy(busy), .frame_done(frame_done), .generation(generation)
  );

  // Model: which phase (0..3) of which cell we are in, and how long we have been there.
  typedef struct packed {
    logic active;
    int   phase;
    int   elapsed;
    int   waddr;
    int   done_cells;
    int   gen;
    logic single;
    logic fdone;
  } mstate_t;

  mstate_t m = '0;

  function automatic mstate_t model_next(mstate_t s, logic rst, logic r, logic st, logic f);
    mstate_t n = s;
    int d = f ? FD : SD;
    n.fdone = 1'b0;
    if (rst) begin
      n = '0;
    end else if (!s.active) begin
      if (r || st) begin
        n.active = 1'b1; n.phase = 0; n.elapsed = 0; n.single = st;
      end
    end else if (s.elapsed >= d - 1) begin
      n.elapsed = 0;
      if (s.phase < 3) begin
        n.phase = s.phase + 1;
      end else begin
        n.phase = 0;
        n.done_cells = s.done_cells + 1;
        if (s.waddr == N - 1) begin
          n.waddr = 0;
          n.gen = (s.gen + 1) % 65536;
          n.fdone = 1'b1;
          if (!(r && !s.single)) begin
            n.active = 1'b0; n.single = 1'b0;
          end
        end else begin
          n.waddr = s.waddr + 1;
        end
      end
    end else begin
      n.elapsed = s.elapsed + 1;
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m, reset, run, step, fast);

  int passed = 0, total = 0;
  logic cmp_en = 1'b0;

  task automatic check(string nm, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  int cyc = 0, shift_cnt, rule_cnt, wen_cnt, fd_cnt, busy_rise, last_shift, last_rule, last_wen;
  int bad_spacing, pair_bad, max_gap, min_gap;
  logic spacing_on = 1'b0, prev_busy = 1'b0, seen_rule7 = 1'b0;
  int wq[$], fdq[$];
  logic [60:0] got, exp;

  // Per-cycle compare against the model, plus event bookkeeping for the directed checks.
  always @(negedge clk) begin
    cyc++;
    if (cmp_en) begin
      got = {busy, shift_en, rule_en, write_en, frame_done, read_addr, write_addr, generation};
      exp = {m.active,
             m.active && m.phase == 1 && m.elapsed == 0,
             m.active && m.phase == 2 && m.elapsed == 0,
             m.active && m.phase == 3 && m.elapsed == 0 && m.done_cells >= LEAD,
             m.fdone, 20'((m.waddr + LEAD) % N), 20'(m.waddr), 16'(m.gen)};
      total++;
      if (got === exp) passed++;
      else $display("FAIL cycle %0d model compare: got %h expected %h", cyc, got, exp);
    end
    if (shift_en) begin shift_cnt++; last_shift = cyc; end
    if (rule_en) begin
      rule_cnt++;
      if (spacing_on && cyc - last_shift != 3) bad_spacing++;
      last_rule = cyc;
      if (write_addr == 20'd7) seen_rule7 = 1'b1;
    end
    if (write_en) begin
      wen_cnt++;
      wq.push_back(int'(write_addr));
      if (int'(read_addr) != (int'(write_addr) + 5) % 12) pair_bad++;
      if (spacing_on && cyc - last_rule != 3) bad_spacing++;
      if (last_wen >= 0) begin
        if (cyc - last_wen > max_gap) max_gap = cyc - last_wen;
        if (cyc - last_wen < min_gap) min_gap = cyc - last_wen;
      end
      last_wen = cyc;
    end
    if (frame_done) begin fd_cnt++; fdq.push_back(cyc); end
    if (busy && !prev_busy) busy_rise = cyc;
    prev_busy = busy;
  end

  task automatic clear();
    shift_cnt = 0; rule_cnt = 0; wen_cnt = 0; fd_cnt = 0; busy_rise = 0;
    last_shift = -100; last_rule = -100; last_wen = -1;
    bad_spacing = 0; pair_bad = 0; max_gap = 0; min_gap = 1000000;
    wq.delete(); fdq.delete();
  endtask

  task automatic tick_n(int k = 1);
    repeat (k) begin @(negedge clk); #1; end
  endtask

  task automatic pulse_step();
    step = 1'b1; tick_n(); step = 1'b0;
  endtask

  task automatic wait_idle(int bound, string nm);
    for (int i = 0; i < bound; i++) begin
      if (!busy) break;
      tick_n();
    end
    check(nm, int'(busy), 0);
  endtask

  function automatic int order_ok();
    if (wq.size() != N) return 0;
    for (int i = 0; i < N; i++) if (wq[i] != i) return 0;
    return 1;
  endfunction

  initial begin
    clear();
    tick_n(); cmp_en = 1'b1; tick_n(2);
    reset = 1'b0; clear(); tick_n(20);
    check("idle_busy", int'(busy), 0);
    check("idle_read_addr", int'(read_addr), 5);
    check("idle_write_addr", int'(write_addr), 0);
    check("idle_strobes", shift_cnt + rule_cnt + wen_cnt + fd_cnt, 0);
    check("idle_generation", int'(generation), 0);

    // First step: priming suppresses 5 writes.
    clear(); fast = 1'b1; pulse_step(); wait_idle(300, "gen1_idle");
    check("gen1_shift", shift_cnt, 12);
    check("gen1_rule", rule_cnt, 12);
    check("gen1_write", wen_cnt, 7);
    check("gen1_frame_done", fd_cnt, 1);
    check("gen1_generation", int'(generation), 1);
    check("gen1_clocks", (fdq.size() > 0) ? fdq[0] - busy_rise : -1, 96);

    // Second step: all 12 writes, in order, paired with read lead.
    clear(); pulse_step(); wait_idle(300, "gen2_idle");
    check("gen2_write", wen_cnt, 12);
    check("gen2_order", order_ok(), 1);
    check("gen2_pairing", pair_bad, 0);
    check("gen2_generation", int'(generation), 2);

    // Run for three slow generations.
    clear(); fast = 1'b0; spacing_on = 1'b1; run = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (fdq.size() >= 2) break;
      tick_n();
    end
    run = 1'b0; wait_idle(300, "run_idle"); spacing_on = 1'b0;
    check("run_frames", fd_cnt, 3);
    check("run_gen_a", (fdq.size() > 0) ? fdq[0] - busy_rise : -1, 144);
    check("run_gen_b", (fdq.size() > 1) ? fdq[1] - fdq[0] : -1, 144);
    check("run_gen_c", (fdq.size() > 2) ? fdq[2] - fdq[1] : -1, 144);
    check("run_spacing", bad_spacing, 0);
    check("run_generation", int'(generation), 5);

    // Toggle fast mid-phase and pulse step while busy.
    clear(); fast = 1'b1; pulse_step();
    for (int i = 0; i < 600; i++) begin
      if (!busy) break;
      fast = 1'($urandom_range(0, 1));
      step = (write_addr <= 20'd9) && ($urandom_range(0, 3) == 0);
      tick_n();
    end
    step = 1'b0; fast = 1'b1;
    check("toggle_idle", int'(busy), 0);
    check("toggle_generation", int'(generation), 6);
    check("toggle_order", order_ok(), 1);
    check("toggle_max_cell", int'(max_gap <= 12), 1);
    check("toggle_min_cell", int'(min_gap >= 8), 1);

    // Random soak against the model.
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0) run = 1'($urandom_range(0, 1));
      step = ($urandom_range(0, 15) == 0);
      fast = ($urandom_range(0, 7) != 0);
      tick_n();
    end
    run = 1'b0; step = 1'b0; fast = 1'b1;
    wait_idle(400, "soak_idle");

    // Reset during RULE of cell 7.
    clear(); seen_rule7 = 1'b0; pulse_step();
    for (int i = 0; i < 200; i++) begin
      if (seen_rule7) break;
      tick_n();
    end
    check("reach_rule7", int'(seen_rule7), 1);
    reset = 1'b1; tick_n();
    check("rst_busy", int'(busy), 0);
    check("rst_read_addr", int'(read_addr), 5);
    check("rst_write_addr", int'(write_addr), 0);
    check("rst_generation", int'(generation), 0);
    check("rst_strobes", int'({shift_en, rule_en, write_en, frame_done}), 0);
    reset = 1'b0; wen_cnt = 0; tick_n(20);
    check("rst_no_write", wen_cnt, 0);
    check("rst_stays_idle", int'(busy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
